// File: rtl/fp_cvt_widen.sv
// Two-stage IEEE-754 widening converter (narrow float in, wide float out).
// Stage 1 classifies the input and counts leading zeros; stage 2 assembles the result.
module fp_cvt_widen #(
  parameter int SEW  = 8,
  parameter int SSW  = 23,
  parameter int DEW  = 11,
  parameter int DSW  = 52,
  parameter int TAGW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEW+SSW:0]     in_data,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DEW+DSW:0]     out_data,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_invalid,
  output logic                 out_denorm
);

  localparam int LZW = $clog2(SSW + 1);
  localparam logic [DEW-1:0] EOFF = DEW'((2 ** (DEW - 1)) - (2 ** (SEW - 1)));
  localparam logic [DEW-1:0] EMAX = {DEW{1'b1}};

  typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_QNAN, C_SNAN} cls_t;

  logic             in_sign;
  logic [SEW-1:0]   in_exp;
  logic [SSW-1:0]   in_sig;
  cls_t             in_cls;
  logic [LZW-1:0]   in_lz;
  logic             lz_found;

  logic             s1_valid, s1_sign;
  cls_t             s1_cls;
  logic [SEW-1:0]   s1_exp;
  logic [SSW-1:0]   s1_sig;
  logic [LZW-1:0]   s1_lz;
  logic [TAGW-1:0]  s1_tag;

  logic             s2_valid, s2_inv, s2_den;
  logic [DEW+DSW:0] s2_data;
  logic [TAGW-1:0]  s2_tag;

  logic             s1_load, s2_load, accept;
  logic [DEW-1:0]   res_exp;
  logic [DSW-1:0]   res_sig;
  logic [SSW-1:0]   sub_sig;

  assign in_sign = in_data[SEW+SSW];
  assign in_exp  = in_data[SSW +: SEW];
  assign in_sig  = in_data[SSW-1:0];

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_cls = C_NORM;
    if (in_exp == '0)
      in_cls = (in_sig == '0) ? C_ZERO : C_SUB;
    else if (in_exp == {SEW{1'b1}}) begin
      if (in_sig == '0)          in_cls = C_INF;
      else if (in_sig[SSW-1])    in_cls = C_QNAN;
      else                       in_cls = C_SNAN;
    end
  end

  always_comb begin
    in_lz    = '0;
    lz_found = 1'b0;
    for (int i = SSW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (in_sig[i]) lz_found = 1'b1;
        else           in_lz    = in_lz + LZW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= C_ZERO;
      s1_exp   <= '0;
      s1_sig   <= '0;
      s1_lz    <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sign <= in_sign;
        s1_cls  <= in_cls;
        s1_exp  <= in_exp;
        s1_sig  <= in_sig;
        s1_lz   <= in_lz;
        s1_tag  <= in_tag;
      end
    end
  end

  // Subnormal: drop the leading one so the result is normal in the wide format.
  assign sub_sig = (s1_sig << s1_lz) << 1;

  always_comb begin
    res_exp = '0;
    res_sig = '0;
    case (s1_cls)
      C_NORM: begin
        res_exp = {{(DEW-SEW){1'b0}}, s1_exp} + EOFF;
        res_sig = DSW'(s1_sig) << (DSW - SSW);
      end
      C_SUB: begin
        res_exp = EOFF - DEW'(s1_lz);
        res_sig = DSW'(sub_sig) << (DSW - SSW);
      end
      C_INF: res_exp = EMAX;
      C_QNAN, C_SNAN: begin
        res_exp = EMAX;
        res_sig = DSW'(s1_sig | (SSW'(1) << (SSW - 1))) << (DSW - SSW);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_inv   <= 1'b0;
      s2_den   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= {s1_sign, res_exp, res_sig};
        s2_tag  <= s1_tag;
        s2_inv  <= (s1_cls == C_SNAN);
        s2_den  <= (s1_cls == C_SUB);
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_data    = s2_data;
  assign out_tag     = s2_tag;
  assign out_invalid = s2_valid && s2_inv;
  assign out_denorm  = s2_valid && s2_den;

endmodule

// File: tb/tb_fp_cvt_widen.sv
// Bench for fp_cvt_widen (single to double) with an arithmetic value-based reference model.
module tb_fp_cvt_widen;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data;
  logic [3:0]  in_tag, out_tag;
  logic [63:0] out_data;
  logic        out_invalid, out_denorm;

  int n_cmp = 0;
  int n_err = 0;

  fp_cvt_widen dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_invalid(out_invalid), .out_denorm(out_denorm)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // Reference: decode to m * 2^ex, then re-encode with the leading one at bit 52.
  function automatic logic [69:0] ref_model(input logic [31:0] x, input logic [3:0] tag);
    logic        s, inv, den;
    int          e, ex, p;
    logic [22:0] f;
    logic [63:0] y, m;
    s = x[31]; e = int'(x[30:23]); f = x[22:0];
    inv = 1'b0; den = 1'b0; y = '0; p = 0;
    if (e == 255) begin
      if (f == 0) y = {s, 11'h7FF, 52'd0};
      else begin
        y   = {s, 11'h7FF, 1'b1, f[21:0], 29'd0};
        inv = !f[22];
      end
    end else if (e == 0 && f == 0) begin
      y = {s, 63'd0};
    end else begin
      den = (e == 0);
      m   = (e == 0) ? 64'(f) : 64'(f) + (64'd1 << 23);
      ex  = (e == 0) ? -149 : e - 150;
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      m = m << (52 - p);
      y = {s, 11'(ex + p + 1023), m[51:0]};
    end
    return {y, tag, inv, den};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] r;
    logic [22:0] f;
    logic        s;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom_range(0, 7))
      0: r = {s, 8'd0, 23'd0};
      1: r = {s, 8'd0, (f == 0) ? 23'd1 : (f >> $urandom_range(0, 22))};
      2: r = {s, 8'hFF, 23'd0};
      3: r = {s, 8'hFF, 1'b1, f[21:0]};
      4: r = {s, 8'hFF, 1'b0, (f[21:0] == 0) ? 22'd5 : f[21:0]};
      default: r = {s, 8'($urandom_range(1, 254)), f};
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, out_tag, out_invalid, out_denorm} !== 71'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h t=%h i=%b dn=%b, want all zero",
               out_valid, out_data, out_tag, out_invalid, out_denorm);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vin [7]  = '{32'h3F800000, 32'h00000001, 32'h007FFFFF, 32'hFF800000,
                             32'h80000000, 32'h7FC00000, 32'h7F800001};
    logic [63:0] vout [7] = '{64'h3FF0000000000000, 64'h36A0000000000000, 64'h380FFFFFC0000000,
                             64'hFFF0000000000000, 64'h8000000000000000, 64'h7FF8000000000000,
                             64'h7FF8000020000000};
    logic [1:0]  vfl [7]  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    int lat;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = vin[i]; in_tag = 4'(i + 3); out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      n_cmp++;
      if (lat !== 2) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d want 2", i, lat);
      end
      n_cmp++;
      if ({out_data, out_tag, out_invalid, out_denorm} !== {vout[i], 4'(i + 3), vfl[i]}) begin
        n_err++;
        $display("FAIL directed_result[%0d]: in %h got d=%h t=%h i=%b dn=%b want d=%h t=%h i=%b dn=%b",
                 i, vin[i], out_data, out_tag, out_invalid, out_denorm,
                 vout[i], 4'(i + 3), vfl[i][1], vfl[i][0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] d [3];
    logic [69:0] e [3];
    logic [2:0]  rdy;
    int idx, got, last;
    bit consec;
    for (int i = 0; i < 3; i++) begin
      d[i] = rand_float();
      e[i] = ref_model(d[i], 4'(8 + i));
    end
    out_ready = 1'b0; idx = 0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = d[idx]; in_tag = 4'(8 + idx);
      #1;
      rdy[s] = in_ready;
      if (in_ready) idx++;
    end
    n_cmp++;
    if (rdy !== 3'b011) begin
      n_err++;
      $display("FAIL bp_in_ready_pattern: got %b (step2..0) want 011", rdy);
    end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({out_valid, out_data, out_tag, out_invalid, out_denorm} !== {1'b1, e[0]}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h t=%h want v=1 d=%h t=%h",
                 s, out_valid, out_data, out_tag, e[0][69:6], e[0][5:2]);
      end
    end
    got = 0; last = -1; consec = 1'b1;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (idx < 3);
      if (idx < 3) begin in_data = d[idx]; in_tag = 4'(8 + idx); end
      #1;
      if (out_valid) begin
        if (got < 3) begin
          n_cmp++;
          if ({out_data, out_tag, out_invalid, out_denorm} !== e[got]) begin
            n_err++;
            $display("FAIL bp_order[%0d]: got d=%h t=%h want d=%h t=%h",
                     got, out_data, out_tag, e[got][69:6], e[got][5:2]);
          end
        end
        if (last >= 0 && s != last + 1) consec = 1'b0;
        last = s;
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== 3 || consec !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drain: got %0d results consecutive=%b, want 3 consecutive=1", got, consec);
    end
  endtask

  task automatic test_streaming();
    logic [69:0] q [$];
    logic [69:0] exp_v;
    int sent, recv;
    sent = 0; recv = 0;
    @(negedge clk);
    for (int s = 0; s < 106; s++) begin
      if (s > 0) @(negedge clk);
      out_ready = 1'b1;
      in_valid = (sent < 100);
      in_data = rand_float();
      in_tag = 4'($urandom);
      #1;
      n_cmp++;
      if (out_valid !== (s >= 2 && s < 102)) begin
        n_err++;
        $display("FAIL stream_valid[%0d]: got %b want %b", s, out_valid, (s >= 2 && s < 102));
      end
      if (out_valid) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++;
        if ({out_data, out_tag, out_invalid, out_denorm} !== exp_v) begin
          n_err++;
          $display("FAIL stream_data[%0d]: got d=%h t=%h i=%b dn=%b want d=%h t=%h i=%b dn=%b",
                   recv, out_data, out_tag, out_invalid, out_denorm,
                   exp_v[69:6], exp_v[5:2], exp_v[1], exp_v[0]);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_data, in_tag));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (recv !== 100) begin
      n_err++;
      $display("FAIL stream_count: got %0d want 100", recv);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic [69:0] e;
    int lat;
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = rand_float(); in_tag = 4'(s);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_prefill: got out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_tag, out_invalid, out_denorm} !== 71'd0) begin
      n_err++;
      $display("FAIL midrst_async: got v=%b d=%h t=%h want all zero", out_valid, out_data, out_tag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_stale[%0d]: got out_valid=%b want 0", s, out_valid);
      end
    end
    d = 32'h40490FDB;
    e = ref_model(d, 4'hA);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_tag = 4'hA;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 2 || {out_data, out_tag, out_invalid, out_denorm} !== e) begin
      n_err++;
      $display("FAIL midrst_next: lat=%0d d=%h t=%h, want lat=2 d=%h t=%h",
               lat, out_data, out_tag, e[69:6], e[5:2]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
